game_input_conditioner: RTL



---
 rtl/game_input_conditioner_if.sv | 23 ++
 rtl/game_input_conditioner.sv | 137 +++++++++++++
 2 files changed

// File: rtl/game_input_conditioner_if.sv
// Pad-side bundle of game_input_conditioner: the four raw buttons in, and the paced
// move_clock plus the conditioned direction requests out.
interface game_input_conditioner_if;
  logic btn_left_raw;
  logic btn_right_raw;
  logic btn_up_raw;
  logic btn_down_raw;
  logic move_clock;
  logic left;
  logic right;
  logic up;
  logic down;

  modport master (
    output btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw,
    input  move_clock, left, right, up, down
  );

  modport slave (
    input  btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw,
    output move_clock, left, right, up, down
  );
endinterface

// File: rtl/game_input_conditioner.sv
// Button synchroniser/debouncer, move_clock generator and request latch for the player sprite.
// Optional MOVE_ACCEL_EN: halve the move_clock half period after ACCEL_TICKS rises of continuous hold.
module game_input_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int MOVE_HALF_PERIOD = 125000,
  parameter int CNT_W            = 20,
  parameter int ACCEL_TICKS      = 64
) (
  input logic                     clock,
  input logic                     reset_n,
  game_input_conditioner_if.slave pads
);

  // Bit order of every per-button vector: 0 left, 1 right, 2 up, 3 down.
  localparam int N_BTN = 4;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync_q;
  logic [N_BTN-1:0] stable_q;
  logic [CNT_W-1:0] db_cnt [N_BTN];
  logic [N_BTN-1:0] resolved;
  logic [N_BTN-1:0] req_q;
  logic [CNT_W-1:0] move_cnt;
  logic [CNT_W-1:0] half_limit;
  logic             move_clk_q;
  logic             wrap;

  assign raw = {pads.btn_down_raw, pads.btn_up_raw, pads.btn_right_raw, pads.btn_left_raw};

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // NOTE: the per-button counters are a handful of flops, not a RAM, so they take the async reset too.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[i] <= sync_q[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Opposing presses cancel within their own axis only, so diagonals pass.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    resolved    = '0;
    resolved[0] = stable_q[0] & ~stable_q[1];
    resolved[1] = stable_q[1] & ~stable_q[0];
    resolved[2] = stable_q[2] & ~stable_q[3];
    resolved[3] = stable_q[3] & ~stable_q[2];
  end

  assign wrap = (move_cnt == half_limit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      move_cnt   <= '0;
      move_clk_q <= 1'b0;
    end else if (wrap) begin
      move_cnt   <= '0;
      move_clk_q <= ~move_clk_q;
    end else begin
      move_cnt <= move_cnt + CNT_W'(1);
    end
  end

  // Requests change only as move_clock falls, keeping them flat around every rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
    end else if (wrap && move_clk_q) begin
      req_q <= resolved;
    end
  end

`ifdef MOVE_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [CNT_W-1:0]  limit_q;

  always_comb begin
    hold_next = hold_cnt;
    if (wrap) begin
      if (move_clk_q) begin
        if (resolved == '0) hold_next = '0;
      end else if ((req_q != '0) && (hold_cnt != HOLD_W'(ACCEL_TICKS))) begin
        hold_next = hold_cnt + HOLD_W'(1);
      end
    end
  end

  // The limit is only reloaded on a wrap, so a half period is never cut short.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      limit_q  <= CNT_W'(MOVE_HALF_PERIOD - 1);
    end else begin
      hold_cnt <= hold_next;
      if (wrap) begin
        limit_q <= (hold_next == HOLD_W'(ACCEL_TICKS)) ? CNT_W'(MOVE_HALF_PERIOD / 2 - 1)
                                                       : CNT_W'(MOVE_HALF_PERIOD - 1);
      end
    end
  end

  assign half_limit = limit_q;
`else
  assign half_limit = CNT_W'(MOVE_HALF_PERIOD - 1);
`endif

  assign pads.move_clock = move_clk_q;
  assign pads.left       = req_q[0];
  assign pads.right      = req_q[1];
  assign pads.up         = req_q[2];
  assign pads.down       = req_q[3];

endmodule
